globallocal_out_buffer: RTL

//  Downstream stage of the GlobalLocal model. Consumes integer messages from its blocking output port
//  (b_out / b_out_notify / b_out_sync), holds them in a DEPTH-entry FIFO, and re-offers them in order
//  on a blocking output port using the same sync/notify handshake. Isolates GlobalLocal from stalls
//  in the consumer that follows.

---
 rtl/globallocal_buffer_pkg.sv | 15 +
 rtl/globallocal_out_buffer_if.sv | 22 ++
 rtl/gl_msg_fifo_mem.sv | 41 ++++
 rtl/globallocal_out_buffer.sv | 109 ++++++++++
 4 files changed

// File: rtl/globallocal_buffer_pkg.sv
// rtl/globallocal_buffer_pkg.sv - shared types and defaults for the GlobalLocal output buffer
package globallocal_buffer_pkg;

    localparam int GL_BUF_DEPTH_DEFAULT = 4;
    localparam int GL_MSG_W             = 32;

    typedef logic [GL_MSG_W-1:0] gl_msg_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } gl_buf_state_e;

endpackage

// File: rtl/globallocal_out_buffer_if.sv
// rtl/globallocal_out_buffer_if.sv - sync/notify handshake bundle for both sides of the buffer
interface globallocal_out_buffer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_sync;
    logic              in_notify;
    logic [DATA_W-1:0] out_data;
    logic              out_sync;
    logic              out_notify;

    // slave: the buffer itself; master: the surrounding producer/consumer pair
    modport slave (
        input  in_data, in_sync, out_sync,
        output in_notify, out_data, out_notify
    );

    modport master (
        output in_data, in_sync, out_sync,
        input  in_notify, out_data, out_notify
    );
endinterface

// File: rtl/gl_msg_fifo_mem.sv
// rtl/gl_msg_fifo_mem.sv - message storage with wrapping write/read pointers, no flow control
module gl_msg_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_look;

    // rd_data is the word that will be at the head once this cycle's read retires
    assign rd_look = rd_ptr + PTR_W'(rd_en);
    assign rd_data = mem[rd_look];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/globallocal_out_buffer.sv
// rtl/globallocal_out_buffer.sv - FWFT output buffer for GlobalLocal; optional GL_OUT_BUFFER_CHECKSUM_EN
module globallocal_out_buffer
    import globallocal_buffer_pkg::*;
#(
    parameter  int DEPTH  = GL_BUF_DEPTH_DEFAULT,
    parameter  int DATA_W = 32,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    globallocal_out_buffer_if.slave  bus,
    input  logic                     flush,
    output logic [LVL_W-1:0]         level,
    output logic [DATA_W-1:0]        checksum
);
    gl_buf_state_e     state, next_state;
    logic [LVL_W-1:0]  level_q, level_next;
    logic [DATA_W-1:0] out_data_q, out_data_next;
    logic              in_notify_q;
    logic              out_notify_q;
    logic              push, pop;
    logic [DATA_W-1:0] rd_data;

    assign push = bus.in_sync && in_notify_q;
    assign pop  = out_notify_q && bus.out_sync;

    gl_msg_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (push && !flush),
        .wr_data (bus.in_data),
        .rd_en   (pop && !flush),
        .rd_data (rd_data)
    );

    always_comb begin
        next_state    = state;
        level_next    = level_q;
        out_data_next = out_data_q;
        if (flush) begin
            next_state = ST_EMPTY;
            level_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_next = level_q + 1'b1;
                2'b01:   level_next = level_q - 1'b1;
                default: level_next = level_q;
            endcase
            unique case (state)
                ST_EMPTY:  if (push) next_state = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (push && !pop && level_q == LVL_W'(DEPTH - 1))
                        next_state = ST_FULL;
                    else if (pop && !push && level_q == LVL_W'(1))
                        next_state = ST_EMPTY;
                end
                ST_FULL:   if (pop) next_state = ST_ACTIVE;
                default:   next_state = ST_EMPTY;
            endcase
            // Head after this cycle: still stored, bypassed from the input, or stale
            if (level_q > LVL_W'(pop))
                out_data_next = rd_data;
            else if (push)
                out_data_next = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            level_q      <= '0;
            out_data_q   <= '0;
            in_notify_q  <= 1'b1;
            out_notify_q <= 1'b0;
        end else begin
            state        <= next_state;
            level_q      <= level_next;
            out_data_q   <= out_data_next;
            in_notify_q  <= (next_state != ST_FULL);
            out_notify_q <= (next_state != ST_EMPTY);
        end
    end

    assign bus.in_notify  = in_notify_q;
    assign bus.out_notify = out_notify_q;
    assign bus.out_data   = out_data_q;
    assign level          = level_q;

`ifdef GL_OUT_BUFFER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            checksum_q <= '0;
        end else if (push) begin
            checksum_q <= checksum_q + bus.in_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule
